tlb_req_issuer: RTL
===================

Name: tlb_req_issuer

Overview:
- Data-side TLB request stage in MEM, directly downstream of the exception checker.
- Consumes the checker's pending_exc. Only issues a translation request to the shared TLB when no exception is pending.
- Handles the kseg0/kseg1 unmapped bypass and holds a registered translation result (paddr, cacheability, TLB exception) until the memory stage consumes it.
- Tolerates pipeline flush while a TLB handshake is outstanding.

Parameters:
- VPN2_W, 19, virtual page-pair number width (vaddr[31:13]).
- PFN_W, 20, physical frame number width.
- CACHED_C, 3'd3, TLB C-field value treated as cacheable.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- flush  in  1  pipeline flush (exception/eret); kills the current access.
- req_valid  in  1  MEM stage presents a load/store.
- req_vaddr  in  32  virtual address.
- req_write  in  1  1 = store.
- pending_exc  in  1  exception checker result: earlier exception pending or CP0 not ready.
- req_ready  out  1  block can accept a request.
- tlb_req  out  1  TLB lookup request.
- tlb_vpn2  out  VPN2_W  lookup VPN2.
- tlb_odd  out  1  vaddr[12], even/odd page select.
- tlb_ack  in  1  TLB lookup complete (single-cycle pulse).
- tlb_hit  in  1  lookup result: entry found.
- tlb_v  in  1  lookup result: valid bit.
- tlb_d  in  1  lookup result: dirty bit.
- tlb_pfn  in  PFN_W  lookup result: frame number.
- tlb_c  in  3  lookup result: cache attribute.
- resp_valid  out  1  translation result valid.
- resp_ready  in  1  consumer takes the result.
- paddr  out  32  physical address.
- paddr_cached  out  1  access is cacheable.
- tlb_exc  out  2  tlb_exc_t encoding: 00 NO_EXC, 01 REFILL, 10 INVALID, 11 MODIFIED.

Behaviour:
- States: IDLE, LOOKUP, DONE, DRAIN.
- Reset (any state, next edge): state=IDLE; tlb_req, resp_valid, paddr, paddr_cached, tlb_exc all 0.
- req_ready = (state==IDLE).
- IDLE, flush=1: no action.
- IDLE, req_valid && pending_exc: no TLB traffic, no response, stay IDLE. The exception propagates through the pipeline untouched.
- IDLE, req_valid && !pending_exc && !flush:
  - Latch vaddr and write.
  - If vaddr[31:30]==2'b10 (kseg0/1): go to DONE with paddr={3'b000,vaddr[28:0]}, paddr_cached=!vaddr[29], tlb_exc=NO_EXC. resp_valid is seen the next cycle.
  - Otherwise go to LOOKUP.
- LOOKUP:
  - tlb_req=1. tlb_vpn2 and tlb_odd come from latched registers and are stable until ack.
  - On tlb_ack, go to DONE with:
    - tlb_exc priority: !hit→REFILL; else !v→INVALID; else write&&!d→MODIFIED; else NO_EXC.
    - paddr={tlb_pfn,vaddr[11:0]}.
    - paddr_cached=(tlb_c==CACHED_C).
  - tlb_req deasserts in the cycle after ack.
- DONE:
  - resp_valid=1; outputs held stable.
  - resp_ready → IDLE (one bubble before the next accept).
- flush in LOOKUP: the handshake cannot be aborted. Go to DRAIN, keep tlb_req=1 until ack, discard the result, then IDLE. resp_valid is never raised for a flushed access.
- flush in DONE: → IDLE next cycle; resp_valid drops. flush overrides resp_ready.
- ack in the same cycle as flush in LOOKUP: result discarded, → IDLE directly.
- tlb_ack outside LOOKUP/DRAIN: ignored.
- Latency:
  - Unmapped: 1 cycle (accept→resp_valid).
  - Mapped: 1 cycle + TLB wait. Minimum 2 cycles (ack in the first LOOKUP cycle).

Optional Feature:
- Macro: TLB_REQ_UTLB_EN.
- When defined:
  - One-entry micro-TLB holding {vpn2, odd, pfn, d, c} of the last successful lookup, i.e. hit && v.
  - A mapped request matching vpn2 and odd goes IDLE→DONE directly, with no tlb_req.
  - MODIFIED is still computed from the cached d.
  - Entry is invalidated on rst and on flush. CP0 TLB writes always cause a flush, so no extra port is needed.
  - REFILL/INVALID results are never cached.
- When undefined: every mapped access performs a TLB lookup; no micro-TLB state exists.

Test Plan:
- kseg0 load vaddr=0x8000_1234 → resp_valid next cycle; paddr=0x0000_1234, cached=1, exc=00, tlb_req never 1.
- kseg1 vaddr=0xA000_0010 → paddr=0x0000_0010, cached=0.
- Mapped store vaddr=0x0040_3008, ack after 3 cycles with hit=1, v=1, d=0, pfn=0x12345 → tlb_vpn2=0x00201 and tlb_odd=1 held for 3 cycles; tlb_exc=11, paddr=0x1234_5008.
- Miss (hit=0) → exc=01; hit=1, v=0 → exc=10; hit=1, v=1, d=1, c=3, load → exc=00, cached=1. resp_valid held with resp_ready=0 for 4 cycles, outputs unchanged.
- pending_exc=1 with req_valid=1 → no tlb_req, no resp_valid. flush in LOOKUP → tlb_req stays high until ack, no resp_valid, req_ready=1 the cycle after ack.
- With TLB_REQ_UTLB_EN: two loads to 0x0040_3000 and 0x0040_3FFC → second produces no tlb_req, resp_valid 1 cycle after accept. After flush, the same load issues tlb_req again.

Source files
------------

// File: rtl/tlb_req_issuer_if.sv
// Handshake bundle for tlb_req_issuer: MEM request, shared-TLB lookup and translation response.
// slave is the issuer's view, master the surrounding pipeline/TLB view.
interface tlb_req_issuer_if #(
  parameter int VPN2_W = 19,
  parameter int PFN_W  = 20
);
  logic              flush;
  logic              req_valid;
  logic [31:0]       req_vaddr;
  logic              req_write;
  logic              pending_exc;
  logic              req_ready;

  logic              tlb_req;
  logic [VPN2_W-1:0] tlb_vpn2;
  logic              tlb_odd;
  logic              tlb_ack;
  logic              tlb_hit;
  logic              tlb_v;
  logic              tlb_d;
  logic [PFN_W-1:0]  tlb_pfn;
  logic [2:0]        tlb_c;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       paddr;
  logic              paddr_cached;
  logic [1:0]        tlb_exc;

  modport slave (
    input  flush, req_valid, req_vaddr, req_write, pending_exc,
    input  tlb_ack, tlb_hit, tlb_v, tlb_d, tlb_pfn, tlb_c, resp_ready,
    output req_ready, tlb_req, tlb_vpn2, tlb_odd,
    output resp_valid, paddr, paddr_cached, tlb_exc
  );

  modport master (
    output flush, req_valid, req_vaddr, req_write, pending_exc,
    output tlb_ack, tlb_hit, tlb_v, tlb_d, tlb_pfn, tlb_c, resp_ready,
    input  req_ready, tlb_req, tlb_vpn2, tlb_odd,
    input  resp_valid, paddr, paddr_cached, tlb_exc
  );
endinterface

// File: rtl/tlb_req_issuer.sv
// Data-side TLB request stage (MEM): kseg0/1 bypass, shared-TLB handshake, registered result.
// Define TLB_REQ_UTLB_EN to add a one-entry micro-TLB that skips the lookup on a repeat page.
module tlb_req_issuer #(
  parameter int         VPN2_W   = 19,
  parameter int         PFN_W    = 20,
  parameter logic [2:0] CACHED_C = 3'd3
) (
  input  logic            clk,
  input  logic            rst,
  tlb_req_issuer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOOKUP, DONE, DRAIN} state_t;
  typedef enum logic [1:0] {NO_EXC = 2'b00, REFILL = 2'b01, INVALID = 2'b10, MODIFIED = 2'b11} tlb_exc_t;
  typedef struct packed {
    logic [31:0] paddr;
    logic        cached;
    tlb_exc_t    exc;
  } resp_t;

  state_t            state;
  logic [VPN2_W-1:0] vpn2_q;
  logic              odd_q;
  logic [11:0]       off_q;
  logic              write_q;
  logic              tlb_req_q;
  logic              resp_valid_q;
  resp_t             resp_q;

  logic [VPN2_W-1:0] req_vpn2;
  logic              accept;
  logic              unmapped;
  resp_t             kseg_resp;
  resp_t             lookup_resp;
  resp_t             utlb_resp;
  logic              utlb_hit;

  function automatic tlb_exc_t exc_of(input logic hit, input logic v, input logic d, input logic wr);
    if (!hit)          return REFILL;
    else if (!v)       return INVALID;
    else if (wr && !d) return MODIFIED;
    else               return NO_EXC;
  endfunction

  assign req_vpn2 = bus.req_vaddr[31:32-VPN2_W];
  assign unmapped = (bus.req_vaddr[31:30] == 2'b10);
  // A pending exception must leave the access untouched so it reaches WB with the faulting instruction.
  assign accept   = (state == IDLE) && bus.req_valid && !bus.pending_exc && !bus.flush;

  always_comb begin
    kseg_resp        = '0;
    kseg_resp.paddr  = {3'b000, bus.req_vaddr[28:0]};
    kseg_resp.cached = !bus.req_vaddr[29];
    kseg_resp.exc    = NO_EXC;
  end

  always_comb begin
    lookup_resp        = '0;
    lookup_resp.paddr  = 32'({bus.tlb_pfn, off_q});
    lookup_resp.cached = (bus.tlb_c == CACHED_C);
    lookup_resp.exc    = exc_of(bus.tlb_hit, bus.tlb_v, bus.tlb_d, write_q);
  end

`ifdef TLB_REQ_UTLB_EN
  logic              utlb_vld;
  logic [VPN2_W-1:0] utlb_vpn2;
  logic              utlb_odd;
  logic [PFN_W-1:0]  utlb_pfn;
  logic              utlb_d;
  logic [2:0]        utlb_c;

  assign utlb_hit = utlb_vld && (utlb_vpn2 == req_vpn2) && (utlb_odd == bus.req_vaddr[12]);

  // Only hit&&v results are cached, so the dirty bit is the only exception source left on a utlb hit.
  always_comb begin
    utlb_resp        = '0;
    utlb_resp.paddr  = 32'({utlb_pfn, bus.req_vaddr[11:0]});
    utlb_resp.cached = (utlb_c == CACHED_C);
    utlb_resp.exc    = exc_of(1'b1, 1'b1, utlb_d, bus.req_write);
  end

  // CP0 TLB writes always flush, so flush is the only coherence event needed.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      utlb_vld <= 1'b0;
    end else if (state == LOOKUP && bus.tlb_ack && bus.tlb_hit && bus.tlb_v) begin
      utlb_vld  <= 1'b1;
      utlb_vpn2 <= vpn2_q;
      utlb_odd  <= odd_q;
      utlb_pfn  <= bus.tlb_pfn;
      utlb_d    <= bus.tlb_d;
      utlb_c    <= bus.tlb_c;
    end
  end
`else
  assign utlb_hit  = 1'b0;
  assign utlb_resp = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      vpn2_q       <= '0;
      odd_q        <= 1'b0;
      off_q        <= '0;
      write_q      <= 1'b0;
      tlb_req_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            vpn2_q  <= req_vpn2;
            odd_q   <= bus.req_vaddr[12];
            off_q   <= bus.req_vaddr[11:0];
            write_q <= bus.req_write;
            if (unmapped) begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
              resp_q       <= kseg_resp;
            end else if (utlb_hit) begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
              resp_q       <= utlb_resp;
            end else begin
              state     <= LOOKUP;
              tlb_req_q <= 1'b1;
            end
          end
        end
        LOOKUP: begin
          if (bus.tlb_ack) begin
            tlb_req_q <= 1'b0;
            if (bus.flush) begin
              state <= IDLE;
            end else begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
              resp_q       <= lookup_resp;
            end
          end else if (bus.flush) begin
            // The shared TLB cannot abort, so keep requesting until it acks and drop the answer.
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.tlb_ack) begin
            state     <= IDLE;
            tlb_req_q <= 1'b0;
          end
        end
        DONE: begin
          if (bus.flush || bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.tlb_req      = tlb_req_q;
  assign bus.tlb_vpn2     = vpn2_q;
  assign bus.tlb_odd      = odd_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.paddr        = resp_q.paddr;
  assign bus.paddr_cached = resp_q.cached;
  assign bus.tlb_exc      = resp_q.exc;
endmodule
